// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - ALU select codes, ALUOp codes, M-extension funct3 and FSM states for alu_exec_ctrl
// The DIV state exists only when ALU_EXEC_DIV_EN is defined.
package alu_exec_pkg;

    localparam logic [3:0] SEL_AND    = 4'b0000;
    localparam logic [3:0] SEL_OR     = 4'b0001;
    localparam logic [3:0] SEL_ADD    = 4'b0010;
    localparam logic [3:0] SEL_XOR    = 4'b0011;
    localparam logic [3:0] SEL_SLL    = 4'b0100;
    localparam logic [3:0] SEL_SRL    = 4'b0101;
    localparam logic [3:0] SEL_SUB    = 4'b0110;
    localparam logic [3:0] SEL_SRA    = 4'b0111;
    localparam logic [3:0] SEL_SLT    = 4'b1000;
    localparam logic [3:0] SEL_SLTU   = 4'b1001;
    localparam logic [3:0] SEL_MULDIV = 4'b1111;

    localparam logic [1:0] OP_MEM = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

`ifdef ALU_EXEC_DIV_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BASIC = 3'd1,
        ST_MUL   = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BASIC = 3'd1,
        ST_MUL   = 3'd2,
        ST_DONE  = 3'd4
    } state_t;
`endif

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] base_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_sel = alt ? SEL_SUB : SEL_ADD;
            3'b001:  base_sel = SEL_SLL;
            3'b010:  base_sel = SEL_SLT;
            3'b011:  base_sel = SEL_SLTU;
            3'b100:  base_sel = SEL_XOR;
            3'b101:  base_sel = alt ? SEL_SRA : SEL_SRL;
            3'b110:  base_sel = SEL_OR;
            default: base_sel = SEL_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_decode.sv
// rtl/alu_exec_decode.sv - combinational ALUOp/funct decode into ALU select, mul/div flags and illegal
// With ALU_EXEC_DIV_EN undefined, DIV*/REM* decode as illegal.
module alu_exec_decode
    import alu_exec_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       funct7_0,
    output logic [3:0] sel,
    output logic       is_mul,
    output logic       is_div,
    output logic       illegal
);

    always_comb begin
        sel     = SEL_ADD;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            OP_MEM: sel = SEL_ADD;
            OP_BR:  sel = SEL_SUB;
            OP_R: begin
                if (funct7_0) begin
                    sel = SEL_MULDIV;
                    if (!funct3[2]) begin
                        is_mul = 1'b1;
                    end else begin
`ifdef ALU_EXEC_DIV_EN
                        is_div = 1'b1;
`else
                        illegal = 1'b1;
`endif
                    end
                end else begin
                    sel = base_sel(funct3, funct7_5);
                end
            end
            // I-type has no SUB, so bit 30 only matters for the shift-right pair
            default: sel = base_sel(funct3, funct7_5 && (funct3 == 3'b101));
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - ALU control/execute unit: single-cycle base ops, iterative RV-M mul/div
// Define ALU_EXEC_DIV_EN to build the restoring divider; otherwise DIV*/REM* complete as illegal.
module alu_exec_ctrl
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             funct7_0,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [3:0]       sel
);

    localparam int CW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic n);
        mag = n ? -x : x;
    endfunction

    state_t             state, state_nx;
    logic [WIDTH-1:0]   op_a, op_b, res_q;
    logic [3:0]         sel_q;
    logic [2:0]         f3_q;
    logic               ill_q, neg_a, neg_b, fin;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;

    logic [3:0] d_sel;
    logic       d_mul, d_div, d_ill;
    logic       accept, in_sa, in_sb;

    alu_exec_decode u_decode (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .funct7_0 (funct7_0),
        .sel      (d_sel),
        .is_mul   (d_mul),
        .is_div   (d_div),
        .illegal  (d_ill)
    );

    assign accept = in_valid && in_ready;

    always_comb begin
        in_sa = 1'b0;
        in_sb = 1'b0;
        if (d_mul) begin
            in_sa = (funct3 != F3_MULHU);
            in_sb = (funct3 == F3_MUL) || (funct3 == F3_MULH);
        end else if (d_div) begin
            in_sa = (funct3 == F3_DIV) || (funct3 == F3_REM);
            in_sb = in_sa;
        end
    end

    logic [WIDTH-1:0] mag_a, alu_res, mul_res;
    logic [CW-1:0]    shamt;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] mul_nx, prod;

    assign mag_a = mag(op_a, neg_a);
    assign shamt = op_b[CW-1:0];

    always_comb begin
        alu_res = '0;
        case (sel_q)
            SEL_AND:  alu_res = op_a & op_b;
            SEL_OR:   alu_res = op_a | op_b;
            SEL_ADD:  alu_res = op_a + op_b;
            SEL_XOR:  alu_res = op_a ^ op_b;
            SEL_SLL:  alu_res = op_a << shamt;
            SEL_SRL:  alu_res = op_a >> shamt;
            SEL_SUB:  alu_res = op_a - op_b;
            SEL_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            SEL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            default:  alu_res = '0;
        endcase
    end

    // Shift-add, LSB first: the low half starts as |b| and drains as the product fills in
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    assign mul_nx  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    assign prod    = (neg_a ^ neg_b) ? -acc : acc;
    assign mul_res = (f3_q == F3_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

`ifdef ALU_EXEC_DIV_EN
    logic [WIDTH-1:0]   mag_b, quo, rem, div_res;
    logic [WIDTH:0]     div_sh, div_df;
    logic [2*WIDTH-1:0] div_nx;
    logic               is_rem;

    assign mag_b  = mag(op_b, neg_b);
    // acc holds {partial remainder, dividend shifting into quotient}
    assign div_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_df = div_sh - {1'b0, mag_b};
    assign div_nx = div_df[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {div_df[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign quo    = acc[WIDTH-1:0];
    assign rem    = acc[2*WIDTH-1:WIDTH];
    assign is_rem = (f3_q == F3_REM) || (f3_q == F3_REMU);

    always_comb begin
        if (op_b == '0)
            div_res = is_rem ? op_a : '1;
        else if (is_rem)
            div_res = neg_a ? -rem : rem;
        else
            div_res = (neg_a ^ neg_b) ? -quo : quo;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (d_mul)
                        state_nx = ST_MUL;
`ifdef ALU_EXEC_DIV_EN
                    else if (d_div)
                        state_nx = ST_DIV;
`endif
                    else
                        state_nx = ST_BASIC;
                end
            end
            ST_BASIC: state_nx = ST_DONE;
            ST_MUL:   if (fin) state_nx = ST_DONE;
`ifdef ALU_EXEC_DIV_EN
            ST_DIV:   if (fin) state_nx = ST_DONE;
`endif
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // fin marks the extra cycle after the last iteration where sign correction is registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res_q <= '0;
            sel_q <= '0;
            f3_q  <= '0;
            ill_q <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            fin   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            if (accept) begin
                op_a  <= a;
                op_b  <= b;
                sel_q <= d_sel;
                f3_q  <= funct3;
                ill_q <= d_ill;
                neg_a <= in_sa && a[WIDTH-1];
                neg_b <= in_sb && b[WIDTH-1];
                fin   <= 1'b0;
                cnt   <= CW'(WIDTH - 1);
                acc   <= d_div ? {{WIDTH{1'b0}}, mag(a, in_sa && a[WIDTH-1])}
                               : {{WIDTH{1'b0}}, mag(b, in_sb && b[WIDTH-1])};
            end
            case (state)
                ST_BASIC: res_q <= ill_q ? '0 : alu_res;
                ST_MUL: begin
                    if (fin) begin
                        res_q <= mul_res;
                    end else begin
                        acc <= mul_nx;
                        if (cnt == '0) fin <= 1'b1;
                        else           cnt <= cnt - 1'b1;
                    end
                end
`ifdef ALU_EXEC_DIV_EN
                ST_DIV: begin
                    if (fin) begin
                        res_q <= div_res;
                    end else begin
                        acc <= div_nx;
                        if (cnt == '0) fin <= 1'b1;
                        else           cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = res_q;
    assign zero      = (res_q == '0);
    assign illegal   = ill_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - directed scoreboard bench for alu_exec_ctrl (WIDTH=32)
module tb_alu_exec_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   alu_op = 2'b00;
    logic [2:0]   funct3 = 3'b000;
    logic         funct7_5 = 1'b0;
    logic         funct7_0 = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic [3:0]   sel;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        logic [3:0]   sel;
        int           lat;
    } exp_t;

    exp_t sb[$];

    alu_exec_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .funct7_0  (funct7_0),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"},  in_ready,  1);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".result"},    result,    0);
        check({tag, ".zero"},      zero,      1);
        check({tag, ".illegal"},   illegal,   0);
        check({tag, ".sel"},       sel,       0);
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic f75, input logic f70, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] er, input logic eill,
                         input logic [3:0] esel, input int elat, input int hold);
        exp_t e;
        int   lat;
        int   guard;
        sb.push_back('{er, eill, esel, elat});
        alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
        a = av; b = bv; in_valid = 1'b1;
        out_ready = (hold == 0);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        check({tag, ".latency"}, lat,     e.lat);
        check({tag, ".result"},  result,  e.res);
        check({tag, ".zero"},    zero,    (e.res == '0));
        check({tag, ".illegal"}, illegal, e.ill);
        check({tag, ".sel"},     sel,     e.sel);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_result"},    result,    e.res);
            check({tag, ".hold_in_ready"},  in_ready,  0);
            check({tag, ".hold_out_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".in_ready_after"},  in_ready,  1);
        check({tag, ".out_valid_after"}, out_valid, 0);
    endtask

    localparam logic [W-1:0] MINV = 32'h8000_0000;
    localparam int ML = W + 1;

    initial begin
        #2;
        check_reset_values("reset");
        #20 rst = 1'b0;
        @(posedge clk); #1;

        // tag, alu_op, f3, f7_5, f7_0, a, b, expected, illegal, sel, latency, hold
        do_op("add_mem",  2'b00, 3'b000, 0, 0, 32'd5,  32'd7, 32'd12, 0, 4'b0010, 1, 0);
        do_op("sub_br",   2'b01, 3'b111, 1, 0, 32'd10, 32'd3, 32'd7,  0, 4'b0110, 1, 0);
        do_op("sub_r",    2'b10, 3'b000, 1, 0, 32'd3,  32'd3, 32'd0,  0, 4'b0110, 1, 0);
        do_op("sra_r",    2'b10, 3'b101, 1, 0, MINV, 32'd4, 32'hF800_0000, 0, 4'b0111, 1, 0);
        do_op("srl_i",    2'b11, 3'b101, 0, 0, MINV, 32'd4, 32'h0800_0000, 0, 4'b0101, 1, 0);
        do_op("addi_f75", 2'b11, 3'b000, 1, 0, 32'd10, 32'd3, 32'd13, 0, 4'b0010, 1, 0);
        do_op("sll_mask", 2'b10, 3'b001, 0, 0, 32'd1,  32'd36, 32'd16, 0, 4'b0100, 1, 0);
        do_op("slt",      2'b10, 3'b010, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 4'b1000, 1, 0);
        do_op("sltu",     2'b10, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 4'b1001, 1, 0);
        do_op("xor",      2'b10, 3'b100, 0, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 0, 4'b0011, 1, 0);
        do_op("or_i",     2'b11, 3'b110, 1, 0, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, 0, 4'b0001, 1, 0);
        do_op("and",      2'b10, 3'b111, 0, 0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0, 4'b0000, 1, 0);
        do_op("hold_add", 2'b00, 3'b000, 0, 0, 32'd100, 32'd23, 32'd123, 0, 4'b0010, 1, 5);

        do_op("mulh",     2'b10, 3'b001, 0, 1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0, 4'b1111, ML, 0);
        do_op("mul",      2'b10, 3'b000, 0, 1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 0, 4'b1111, ML, 0);
        do_op("mulhu",    2'b10, 3'b011, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 4'b1111, ML, 0);
        do_op("mulhsu",   2'b10, 3'b010, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 4'b1111, ML, 0);
        do_op("mul_big",  2'b10, 3'b000, 0, 1, 32'd123456, 32'd789, 32'd97406784, 0, 4'b1111, ML, 0);

`ifdef ALU_EXEC_DIV_EN
        do_op("div",      2'b10, 3'b100, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 4'b1111, ML, 0);
        do_op("rem",      2'b10, 3'b110, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 4'b1111, ML, 0);
        do_op("div_by0",  2'b10, 3'b100, 0, 1, 32'd55, 32'd0, 32'hFFFF_FFFF, 0, 4'b1111, ML, 0);
        do_op("remu_by0", 2'b10, 3'b111, 0, 1, 32'h0000_1234, 32'd0, 32'h0000_1234, 0, 4'b1111, ML, 0);
        do_op("rem_by0",  2'b10, 3'b110, 0, 1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 4'b1111, ML, 0);
        do_op("div_ovf",  2'b10, 3'b100, 0, 1, MINV, 32'hFFFF_FFFF, MINV, 0, 4'b1111, ML, 0);
        do_op("rem_ovf",  2'b10, 3'b110, 0, 1, MINV, 32'hFFFF_FFFF, 32'd0, 0, 4'b1111, ML, 0);
        do_op("divu",     2'b10, 3'b101, 0, 1, 32'd100, 32'd7, 32'd14, 0, 4'b1111, ML, 0);
`else
        do_op("div_ill",  2'b10, 3'b100, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'd0, 1, 4'b1111, 1, 0);
        do_op("remu_ill", 2'b10, 3'b111, 0, 1, 32'h0000_1234, 32'd0, 32'd0, 1, 4'b1111, 1, 0);
`endif
        do_op("after_ill", 2'b00, 3'b000, 0, 0, 32'd1, 32'd1, 32'd2, 0, 4'b0010, 1, 0);

        // Abort a multiply part-way through with an asynchronous reset
        alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b1;
        a = 32'd9; b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mul_abort.busy", in_ready, 0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("mul_abort");
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_op("add_post_rst", 2'b00, 3'b000, 0, 0, 32'd5, 32'd7, 32'd12, 0, 4'b0010, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
